// File: rtl/exec_unit.sv
// Single-issue execution stage feeding a 4x8 register file that writes every falling edge.
// write_id/new_data always hold a legal write pair: a fresh result or the last value written.
module exec_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] reg3,
  input  logic [DATA_W-1:0] reg4,
  output logic [1:0]        write_id,
  output logic [DATA_W-1:0] new_data,
  output logic              carry,
  output logic              zero
);

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  state_t              state_r, state_s;
  logic [1:0]          sweep_r;
  logic [2:0]          op_r;
  logic [1:0]          rd_r, rs_r;
  logic [DATA_W-1:0]   imm_r;
  logic [DATA_W-1:0]   rd_val_s, rs_val_s, result_s;
  logic                carry_s, writes_s;
  logic [1:0]          write_id_r;
  logic [DATA_W-1:0]   new_data_r;
  logic                carry_r, zero_r, ready_r;
  logic                unused_rsvd_s;

  // Reserved instruction bit carries no meaning.
  assign unused_rsvd_s = instr[8];

  assign instr_ready = ready_r;
  assign write_id    = write_id_r;
  assign new_data    = new_data_r;
  assign carry       = carry_r;
  assign zero        = zero_r;

  // Operand selection from the register file read ports.
  always_comb begin
    rd_val_s = {DATA_W{1'b0}};
    rs_val_s = {DATA_W{1'b0}};
    case (rd_r)
      2'd0:    rd_val_s = reg1;
      2'd1:    rd_val_s = reg2;
      2'd2:    rd_val_s = reg3;
      2'd3:    rd_val_s = reg4;
      default: rd_val_s = {DATA_W{1'b0}};
    endcase
    case (rs_r)
      2'd0:    rs_val_s = reg1;
      2'd1:    rs_val_s = reg2;
      2'd2:    rs_val_s = reg3;
      2'd3:    rs_val_s = reg4;
      default: rs_val_s = {DATA_W{1'b0}};
    endcase
  end

  // ALU: result and carry/borrow for the latched instruction.
  always_comb begin
    result_s = rd_val_s;
    carry_s  = carry_r;
    writes_s = 1'b1;
    case (op_r)
      OP_NOP:  writes_s = 1'b0;
      OP_LDI:  begin result_s = imm_r;               carry_s = 1'b0; end
      OP_MOV:  begin result_s = rs_val_s;            carry_s = 1'b0; end
      OP_ADD:  {carry_s, result_s} = {1'b0, rd_val_s} + {1'b0, rs_val_s};
      // Bit 8 of the 9-bit difference is the unsigned borrow.
      OP_SUB:  {carry_s, result_s} = {1'b0, rd_val_s} - {1'b0, rs_val_s};
      OP_AND:  begin result_s = rd_val_s & rs_val_s; carry_s = 1'b0; end
      OP_XOR:  begin result_s = rd_val_s ^ rs_val_s; carry_s = 1'b0; end
      OP_ADDI: {carry_s, result_s} = {1'b0, rd_val_s} + {1'b0, imm_r};
      default: writes_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLR:   if (sweep_r == 2'd3) state_s = ST_IDLE; else state_s = ST_CLR;
      ST_IDLE:  if (instr_valid)     state_s = ST_EXEC; else state_s = ST_IDLE;
      ST_EXEC:  if (writes_s)        state_s = ST_WRITE; else state_s = ST_IDLE;
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_CLR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_CLR;
    else        state_r <= state_s;
  end

  // Post-reset sweep counter; index 0 is already being written while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    sweep_r <= 2'd0;
    else if (state_r == ST_CLR && sweep_r != 2'd3) sweep_r <= sweep_r + 2'd1;
    else                                           sweep_r <= sweep_r;
  end

  // Instruction latch, loaded only on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r  <= 3'd0;
      rd_r  <= 2'd0;
      rs_r  <= 2'd0;
      imm_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_IDLE && instr_valid) begin
      op_r  <= instr[15:13];
      rd_r  <= instr[12:11];
      rs_r  <= instr[10:9];
      imm_r <= instr[7:0];
    end else begin
      op_r  <= op_r;
      rd_r  <= rd_r;
      rs_r  <= rs_r;
      imm_r <= imm_r;
    end
  end

  // Write pair and flags; held unless the sweep or a writing op updates them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_id_r <= 2'd0;
      new_data_r <= {DATA_W{1'b0}};
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
    end else if (state_r == ST_CLR && sweep_r != 2'd3) begin
      write_id_r <= sweep_r + 2'd1;
      new_data_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_EXEC && writes_s) begin
      write_id_r <= rd_r;
      new_data_r <= result_s;
      carry_r    <= carry_s;
      zero_r     <= (result_s == {DATA_W{1'b0}});
    end else begin
      write_id_r <= write_id_r;
      new_data_r <= new_data_r;
      carry_r    <= carry_r;
      zero_r     <= zero_r;
    end
  end

  // Ready is registered from the next state so it is high exactly in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_r <= 1'b0;
    else        ready_r <= (state_s == ST_IDLE);
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural falling-edge register file.
module tb_exec_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [1:0]  write_id;
  logic [7:0]  new_data;
  logic        carry, zero;
  logic [7:0]  rf [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  int tests = 0;
  int fails = 0;

  exec_unit #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .reg1(rf[0]), .reg2(rf[1]), .reg3(rf[2]), .reg4(rf[3]),
    .write_id(write_id), .new_data(new_data), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: no write enable, writes on every falling edge.
  always @(negedge clk) rf[write_id] <= new_data;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic r8,
                                     input logic [7:0] imm);
    return {op, rd, rs, r8, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".ready_wait"}, {15'd0, instr_ready}, 16'd1);
  endtask

  task automatic sweep_check(input string tag);
    chk({tag, ".rdy0"}, {15'd0, instr_ready}, 16'd0);
    chk({tag, ".wid0"}, {14'd0, write_id}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk({tag, ".rdy"}, {15'd0, instr_ready}, (k == 4) ? 16'd1 : 16'd0);
      chk({tag, ".wid"}, {14'd0, write_id}, (k == 4) ? 16'd3 : 16'(k));
      chk({tag, ".data"}, {8'd0, new_data}, 16'd0);
    end
    for (int i = 0; i < 4; i++) chk({tag, ".rf"}, {8'd0, rf[i]}, 16'd0);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ins, input logic [1:0] wid,
                       input logic [7:0] data, input logic c, input logic z,
                       input logic is_nop);
    wait_ready(tag);
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    chk({tag, ".busy"}, {15'd0, instr_ready}, 16'd0);
    tick();
    chk({tag, ".rdy_e1"}, {15'd0, instr_ready}, is_nop ? 16'd1 : 16'd0);
    chk({tag, ".wid"}, {14'd0, write_id}, {14'd0, wid});
    chk({tag, ".data"}, {8'd0, new_data}, {8'd0, data});
    chk({tag, ".carry"}, {15'd0, carry}, {15'd0, c});
    chk({tag, ".zero"}, {15'd0, zero}, {15'd0, z});
    if (!is_nop) begin
      @(negedge clk);
      #1;
      chk({tag, ".rf"}, {8'd0, rf[wid]}, {8'd0, data});
      tick();
      chk({tag, ".rdy_e2"}, {15'd0, instr_ready}, 16'd1);
    end
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    repeat (2) tick();
    chk("rst.wid", {14'd0, write_id}, 16'd0);
    chk("rst.data", {8'd0, new_data}, 16'd0);
    chk("rst.flags", {14'd0, carry, zero}, 16'd0);
    reset = 1'b1;
    sweep_check("sweep1");

    do_op("ldi_a5", mk(3'b001, 2'd2, 2'd0, 1'b0, 8'hA5), 2'd2, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_op("ldi_f0", mk(3'b001, 2'd0, 2'd0, 1'b0, 8'hF0), 2'd0, 8'hF0, 1'b0, 1'b0, 1'b0);
    do_op("ldi_20", mk(3'b001, 2'd1, 2'd0, 1'b0, 8'h20), 2'd1, 8'h20, 1'b0, 1'b0, 1'b0);
    do_op("add_ov", mk(3'b011, 2'd0, 2'd1, 1'b0, 8'h00), 2'd0, 8'h10, 1'b1, 1'b0, 1'b0);
    do_op("sub_00", mk(3'b100, 2'd0, 2'd0, 1'b0, 8'h00), 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("ldi_05", mk(3'b001, 2'd0, 2'd0, 1'b0, 8'h05), 2'd0, 8'h05, 1'b0, 1'b0, 1'b0);
    do_op("ldi_07", mk(3'b001, 2'd1, 2'd0, 1'b0, 8'h07), 2'd1, 8'h07, 1'b0, 1'b0, 1'b0);
    do_op("sub_bw", mk(3'b100, 2'd0, 2'd1, 1'b0, 8'h00), 2'd0, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_op("nop",    mk(3'b000, 2'd3, 2'd2, 1'b0, 8'h77), 2'd0, 8'hFE, 1'b1, 1'b0, 1'b1);
    do_op("mov",    mk(3'b010, 2'd3, 2'd2, 1'b0, 8'h00), 2'd3, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_op("and",    mk(3'b101, 2'd3, 2'd0, 1'b0, 8'h00), 2'd3, 8'hA4, 1'b0, 1'b0, 1'b0);
    do_op("xor_r8", mk(3'b110, 2'd3, 2'd3, 1'b1, 8'h00), 2'd3, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("addi_w", mk(3'b111, 2'd0, 2'd0, 1'b0, 8'h02), 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);

    // instr_valid held high: accepts every third edge, dependent chain on r3.
    wait_ready("held");
    instr = mk(3'b111, 2'd3, 2'd0, 1'b0, 8'h01);
    instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("held.rdy", {15'd0, instr_ready}, (k % 3 == 2) ? 16'd1 : 16'd0);
      if (k % 3 == 1) begin
        chk("held.wid", {14'd0, write_id}, 16'd3);
        chk("held.data", {8'd0, new_data}, 16'(k / 3 + 1));
      end
      if (k % 3 == 2) chk("held.rf", {8'd0, rf[3]}, 16'(k / 3 + 1));
    end
    instr_valid = 1'b0;
    tick();
    chk("held.last", {8'd0, new_data}, 16'd4);
    tick();
    chk("held.rf4", {8'd0, rf[3]}, 16'd4);

    // Reset asserted during WRITE of an LDI.
    wait_ready("rstw");
    instr = mk(3'b001, 2'd1, 2'd0, 1'b0, 8'h3C);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rstw.pre", {8'd0, new_data}, 16'h003C);
    reset = 1'b0;
    #1;
    chk("rstw.wid", {14'd0, write_id}, 16'd0);
    chk("rstw.data", {8'd0, new_data}, 16'd0);
    chk("rstw.flags", {14'd0, carry, zero}, 16'd0);
    chk("rstw.rdy", {15'd0, instr_ready}, 16'd0);
    repeat (2) tick();
    reset = 1'b1;
    sweep_check("sweep2");
    do_op("post", mk(3'b001, 2'd2, 2'd0, 1'b0, 8'h5A), 2'd2, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Single-issue execution stage directly upstream of the 4×8-bit register file. Accepts one 16-bit instruction per valid/ready handshake. Reads operands from the register file's four read ports, computes an 8-bit result, and drives the file's `write_id`/`new_data` inputs. The register file has no write enable and writes on every falling clock edge, so this block always presents a legal write pair: either a new result or a rewrite of the last value written.

## Interface
- `DATA_W`, 8, datapath width; only 8 is supported and it must match the register file.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr`  in  16  [15:13] op, [12:11] rd, [10:9] rs, [8] reserved (ignored), [7:0] imm.
- `instr_ready`  out  1  high exactly when the FSM is in IDLE.
- `reg1`..`reg4`  in  8 each  register file read ports; index 0..3 in that order.
- `write_id`  out  2  destination index to the register file; registered.
- `new_data`  out  8  write data to the register file; registered.
- `carry`  out  1  carry/borrow flag of the last arithmetic op; registered.
- `zero`  out  1  result==0 flag of the last writing op; registered.

## Operation
- Opcodes:
  - 000 NOP
  - 001 LDI: rd=imm
  - 010 MOV: rd=rs
  - 011 ADD: rd=rd+rs
  - 100 SUB: rd=rd-rs
  - 101 AND: rd=rd&rs
  - 110 XOR: rd=rd^rs
  - 111 ADDI: rd=rd+imm
- Arithmetic is modulo 256.
  - ADD/ADDI: `carry` = bit 8 of the 9-bit sum.
  - SUB: `carry` = borrow, i.e. 1 iff rd<rs (unsigned).
  - LDI/MOV/AND/XOR: `carry` cleared.
  - `zero` = (result==0) for every writing op.
  - NOP leaves `carry` and `zero` unchanged.
- Operands are read by source/destination index from `reg1`..`reg4` during EXEC.
- States:
  - CLR: post-reset sweep.
  - IDLE: `instr_ready`=1.
  - EXEC: instruction latched; result computed combinationally from latched instruction and read ports.
  - WRITE: result is on the outputs and is captured by the register file at this cycle's falling edge.
- Transitions:
  - CLR→IDLE after the sweep completes.
  - IDLE→EXEC on `instr_valid`&&`instr_ready`.
  - EXEC→WRITE for writing ops.
  - EXEC→IDLE for NOP; all outputs unchanged.
  - WRITE→IDLE unconditionally.
- Hold rule: outside a result update, `write_id`/`new_data` keep their last values. Because this block is the only writer, the register file rewrites an unchanged value every cycle.
- CLR sweep: writes 0 to indices 0,1,2,3 in turn, so all four registers are zero before the first instruction.
- `instr` is sampled only on the accepting edge; changes while busy are ignored. `instr_valid` held high while busy causes no extra accept.
- Reserved bit [8] is ignored.

## Timing
- Reset values (asserted asynchronously):
  - state CLR, sweep count 0
  - `write_id`=0, `new_data`=0, `carry`=0, `zero`=0, `instr_ready`=0
- CLR sequence after reset release:
  - edges R1..R3 set `write_id` to 1,2,3 (`new_data` stays 0).
  - R4 enters IDLE; `write_id` stays 3.
  - First possible accept is R5.
- Instruction timing, where E0 is the accepting edge:
  - E0 latches `instr`; state becomes EXEC and `instr_ready` drops.
  - E1 registers `write_id`=rd, `new_data`=result and the flags; state becomes WRITE.
  - The falling edge between E1 and E2 commits the value to the register file.
  - E2 returns to IDLE; the next accept is possible at E3.
  - Writing-op throughput: one instruction per 3 cycles.
  - NOP: EXEC at E0→E1, IDLE at E1, next accept at E2.
- Read-after-write: the previous result is committed before IDLE. Back-to-back dependent instructions need no stall or forwarding.
- Reset mid-operation (any state):
  - The in-flight instruction is dropped with no partial write beyond values already present.
  - The FSM restarts the CLR sweep.

## Test plan
- Reset then release → `instr_ready` low for exactly 4 edges; reg1..reg4 all read 0x00; `write_id` seen at 0,1,2,3.
- LDI rd=2 imm=0xA5 → `instr_ready` low 2 cycles; `write_id`=2, `new_data`=0xA5 at E1; reg3=0xA5 after E1's falling edge; `zero`=0, `carry`=0.
- LDI r0=0xF0, LDI r1=0x20, ADD rd=0 rs=1 → reg1=0x10, `carry`=1, `zero`=0. Then SUB rd=0 rs=0 → reg1=0x00, `carry`=0, `zero`=1.
- SUB with r0=0x05, r1=0x07 → reg1=0xFE, `carry`=1. Then NOP → outputs and flags unchanged; `instr_ready` back after 1 cycle.
- `instr_valid` held high for 10 cycles with ADDI rd=3 imm=1 from r3=0 → accepts at E0, E3, E6, E9; reg4 reads 1, 2, 3, 4 in sequence.
- Assert reset during WRITE of LDI rd=1 imm=0x3C → outputs zero immediately; CLR sweep reruns; all registers 0 afterwards.
